stack_control: RTL and testbench
================================

STACK_CONTROL -- requirements
Module: stack_control

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the stack capacity checked against pointerA/pointerB.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port instr_valid  in  1  instruction offered.
REQ-005 SHALL have port instr_ready  out  1  controller accepts instruction this cycle.
REQ-006 SHALL have port opcode  in  4  instruction code, sampled on accept.
REQ-007 SHALL have port pointerA/pointerB  in  5 each  datapath stack pointers, 0 = empty, DEPTH = full.
REQ-008 SHALL have port great  in  1  datapath compare result (stackb_reg < storeb_reg).
REQ-009 SHALL have port pushA, popA, pushB, popB  out  1 each  stack strobes.
REQ-010 SHALL have port A, B, C, E  out  1 each  ALU select (A,B), stackb_reg latch (C), storeb_reg latch (E).
REQ-011 SHALL have port d_select  out  2  data mux select: 00 data_in, 01 top, 10 stackb_reg, 11 storeb_reg.
REQ-012 SHALL have port flag  out  1  registered compare result.
REQ-013 SHALL have port err_ovf/err_unf  out  1 each  sticky overflow / underflow.
REQ-014 SHALL have port clr_err  in  1  clears both err bits.

Function
REQ-015 SHALL accept an instruction on a rising edge with instr_valid=1 and instr_ready=1, and latch opcode.
REQ-016 SHALL implement FSM states IDLE, STEP1, STEP2; instr_ready=1 only in IDLE.
REQ-017 SHALL go IDLE->STEP1 on accept, STEP1->STEP2 for two-step opcodes, else STEP1->IDLE; STEP2->IDLE always.
REQ-018 SHALL drive all strobes as Moore outputs of state and latched opcode, each high for exactly one cycle; d_select is 00 when unused.
REQ-019 SHALL decode opcodes: 0 NOP; 1 LDA pushA, d_select=00; 2 DUPA pushA, d_select=01; 3 POPA popA; 5 POPB popB; 6 LATC C; 7 LATE E; 8 PSB pushB, d_select=10; 9 PST pushB, d_select=11.
REQ-020 SHALL execute opcode 4 MOVB as STEP1 pushB, d_select=01, then STEP2 popA.
REQ-021 SHALL execute opcodes 12-15 ALU as STEP1 A=opcode[1], B=opcode[0], then STEP2 pushA, d_select=01.
REQ-022 SHALL execute opcode 11 CMP by loading flag from great at the end of STEP1, with no strobes.
REQ-023 SHALL treat opcodes 10 as NOP.
REQ-024 SHALL suppress any push when its target pointer equals DEPTH, and set err_ovf instead.
REQ-025 SHALL suppress any pop when its target pointer equals 0, and set err_unf instead.
REQ-026 SHALL, on a suppressed MOVB step, abandon the rest of the instruction and return to IDLE.
REQ-027 SHALL never assert push and pop of the same stack in one cycle.
REQ-028 SHALL make clr_err override a same-cycle error set, with clr_err taking priority.
REQ-029 SHALL take 1 cycle per single-step instruction and 2 cycles per two-step instruction, giving back-to-back throughput of one instruction every 2 or 3 cycles.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, enter IDLE and clear all strobes, d_select, flag, err_ovf and err_unf to 0.
REQ-031 SHALL let a mid-instruction reset abort the instruction, so no further strobes occur.
REQ-032 SHALL make instr_ready 0 while rst=0 and 1 in the first cycle after release.

Verification
REQ-033 SHALL pass: LDA with pointerA=3 -> pushA=1, d_select=00 for one cycle, then instr_ready=1 the following cycle.
REQ-034 SHALL pass: MOVB with pointerA=2, pointerB=0 -> cycle1 pushB=1 with d_select=01, cycle2 popA=1, then IDLE.
REQ-035 SHALL pass: DUPA with pointerA=DEPTH=16 -> no pushA, err_ovf=1, which holds until clr_err=1.
REQ-036 SHALL pass: POPB with pointerB=0 -> no popB, err_unf=1; with clr_err in the same cycle, err_unf=0.
REQ-037 SHALL pass: ALU opcode 14 -> A=1, B=0 for one cycle, then pushA with d_select=01.
REQ-038 SHALL pass: CMP with great=1, then rst=0 asserted during STEP2 of a following MOVB -> flag=1 after CMP, then popA never asserts and flag=0 after reset.

Source files
------------

// File: rtl/stack_control.sv
// stack_control: IDLE/STEP1/STEP2 sequencer for a two-stack datapath with overflow/underflow guarding.
// Revision 1.0
`default_nettype none

module stack_control #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] opcode,
  input  logic [4:0] pointerA,
  input  logic [4:0] pointerB,
  input  logic       great,
  output logic       pushA,
  output logic       popA,
  output logic       pushB,
  output logic       popB,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       E,
  output logic [1:0] d_select,
  output logic       flag,
  output logic       err_ovf,
  output logic       err_unf,
  input  logic       clr_err
);

  localparam logic [4:0] c_FULL = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       flag_q, flag_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic       w_push_a, w_pop_a, w_push_b, w_pop_b;
  logic [1:0] w_ds;
  logic       w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic       w_ovf_set, w_unf_set;

  assign w_a_full  = (pointerA == c_FULL);
  assign w_b_full  = (pointerB == c_FULL);
  assign w_a_empty = (pointerA == 5'd0);
  assign w_b_empty = (pointerB == 5'd0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    flag_d   = flag_q;
    w_push_a = 1'b0;
    w_pop_a  = 1'b0;
    w_push_b = 1'b0;
    w_pop_b  = 1'b0;
    w_ds     = 2'b00;
    A        = 1'b0;
    B        = 1'b0;
    C        = 1'b0;
    E        = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          state_d = STEP1;
        end
      end
      STEP1: begin
        state_d = IDLE;
        case (op_q)
          4'd1: w_push_a = 1'b1;
          4'd2: begin w_push_a = 1'b1; w_ds = 2'b01; end
          4'd3: w_pop_a = 1'b1;
          4'd4: begin
            w_push_b = 1'b1;
            w_ds     = 2'b01;
            // A blocked first half of MOVB drops the second half.
            if (!w_b_full) state_d = STEP2;
          end
          4'd5:  w_pop_b = 1'b1;
          4'd6:  C = 1'b1;
          4'd7:  E = 1'b1;
          4'd8:  begin w_push_b = 1'b1; w_ds = 2'b10; end
          4'd9:  begin w_push_b = 1'b1; w_ds = 2'b11; end
          4'd11: flag_d = great;
          4'd12, 4'd13, 4'd14, 4'd15: begin
            A       = op_q[1];
            B       = op_q[0];
            state_d = STEP2;
          end
          default: ;
        endcase
      end
      STEP2: begin
        state_d = IDLE;
        case (op_q)
          4'd4: w_pop_a = 1'b1;
          4'd12, 4'd13, 4'd14, 4'd15: begin w_push_a = 1'b1; w_ds = 2'b01; end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    pushA     = w_push_a & ~w_a_full;
    popA      = w_pop_a  & ~w_a_empty;
    pushB     = w_push_b & ~w_b_full;
    popB      = w_pop_b  & ~w_b_empty;
    d_select  = (pushA | pushB) ? w_ds : 2'b00;
    w_ovf_set = (w_push_a & w_a_full) | (w_push_b & w_b_full);
    w_unf_set = (w_pop_a & w_a_empty) | (w_pop_b & w_b_empty);
    ovf_d     = clr_err ? 1'b0 : (ovf_q | w_ovf_set);
    unf_d     = clr_err ? 1'b0 : (unf_q | w_unf_set);

    // Strobes are masked during reset so an aborted instruction emits nothing further.
    if (!rst) begin
      pushA    = 1'b0;
      popA     = 1'b0;
      pushB    = 1'b0;
      popB     = 1'b0;
      A        = 1'b0;
      B        = 1'b0;
      C        = 1'b0;
      E        = 1'b0;
      d_select = 2'b00;
    end
  end

  assign instr_ready = (state_q == IDLE) & rst;
  assign flag        = flag_q;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_control.sv
// tb_stack_control: directed self-checking bench for stack_control.
// Revision 1.0
`default_nettype none

module tb_stack_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [4:0] pointerA = 5'd0;
  logic [4:0] pointerB = 5'd0;
  logic       great = 1'b0;
  logic       clr_err = 1'b0;
  logic       instr_ready, pushA, popA, pushB, popB, A, B, C, E, flag, err_ovf, err_unf;
  logic [1:0] d_select;
  logic [9:0] strb;

  int checks = 0;
  int errors = 0;

  stack_control #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .pointerA(pointerA), .pointerB(pointerB), .great(great),
    .pushA(pushA), .popA(popA), .pushB(pushB), .popB(popB),
    .A(A), .B(B), .C(C), .E(E), .d_select(d_select), .flag(flag),
    .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // {pushA,popA,pushB,popB,A,B,C,E,d_select[1:0]}
  assign strb = {pushA, popA, pushB, popB, A, B, C, E, d_select};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
    checks++;
    if ({strb, flag, err_ovf, err_unf} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {strb, flag, err_ovf, err_unf});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", instr_ready); end
  endtask

  task automatic test_lda();
    pointerA = 5'd3;
    issue(4'd1);
    checks++;
    if (strb !== 10'b1000_0000_00) begin errors++; $display("FAIL lda_step1 got=%b exp=1000000000", strb); end
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL lda_busy got=%b exp=0", instr_ready); end
    tick();
    checks++;
    if ({instr_ready, strb} !== 11'b1_0000_0000_00) begin
      errors++; $display("FAIL lda_idle got=%b exp=10000000000", {instr_ready, strb});
    end
  endtask

  task automatic test_movb();
    pointerA = 5'd2;
    pointerB = 5'd0;
    issue(4'd4);
    checks++;
    if (strb !== 10'b0010_0000_01) begin errors++; $display("FAIL movb_step1 got=%b exp=0010000001", strb); end
    tick();
    checks++;
    if ({instr_ready, strb} !== 11'b0_0100_0000_00) begin
      errors++; $display("FAIL movb_step2 got=%b exp=00100000000", {instr_ready, strb});
    end
    tick();
    checks++;
    if ({instr_ready, strb} !== 11'b1_0000_0000_00) begin
      errors++; $display("FAIL movb_idle got=%b exp=10000000000", {instr_ready, strb});
    end
  endtask

  task automatic test_overflow();
    pointerA = 5'd16;
    issue(4'd2);
    checks++;
    if (strb !== 10'd0) begin errors++; $display("FAIL dupa_full_strb got=%b exp=0", strb); end
    tick();
    checks++;
    if ({err_ovf, err_unf} !== 2'b10) begin errors++; $display("FAIL ovf_set got=%b exp=10", {err_ovf, err_unf}); end
    tick();
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", err_ovf); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", err_ovf); end
  endtask

  task automatic test_underflow();
    pointerB = 5'd0;
    issue(4'd5);
    checks++;
    if (strb !== 10'd0) begin errors++; $display("FAIL popb_empty_strb got=%b exp=0", strb); end
    tick();
    checks++;
    if ({err_ovf, err_unf} !== 2'b01) begin errors++; $display("FAIL unf_set got=%b exp=01", {err_ovf, err_unf}); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", err_unf); end
    issue(4'd5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_unf !== 1'b0) begin errors++; $display("FAIL unf_clr_priority got=%b exp=0", err_unf); end
  endtask

  task automatic test_alu();
    pointerA = 5'd3;
    issue(4'd14);
    checks++;
    if (strb !== 10'b0000_1000_00) begin errors++; $display("FAIL alu_step1 got=%b exp=0000100000", strb); end
    tick();
    checks++;
    if (strb !== 10'b1000_0000_01) begin errors++; $display("FAIL alu_step2 got=%b exp=1000000001", strb); end
    tick();
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL alu_idle got=%b exp=1", instr_ready); end
  endtask

  task automatic test_single_ops();
    logic [3:0] ops [7];
    logic [9:0] exps [7];
    pointerA = 5'd3;
    pointerB = 5'd0;
    ops  = '{4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd10};
    exps = '{10'b0100_0000_00, 10'b0000_0010_00, 10'b0000_0001_00,
             10'b0010_0000_10, 10'b0010_0000_11, 10'b0000_0000_00, 10'b0000_0000_00};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i]);
      checks++;
      if (strb !== exps[i]) begin errors++; $display("FAIL op%0d_step1 got=%b exp=%b", ops[i], strb, exps[i]); end
      tick();
      checks++;
      if ({instr_ready, strb} !== 11'b1_0000_0000_00) begin
        errors++; $display("FAIL op%0d_idle got=%b exp=10000000000", ops[i], {instr_ready, strb});
      end
    end
  endtask

  task automatic test_movb_abort();
    pointerA = 5'd2;
    pointerB = 5'd16;
    issue(4'd4);
    checks++;
    if (strb !== 10'd0) begin errors++; $display("FAIL movb_full_strb got=%b exp=0", strb); end
    tick();
    checks++;
    if ({instr_ready, popA, err_ovf} !== 3'b101) begin
      errors++; $display("FAIL movb_abort got=%b exp=101", {instr_ready, popA, err_ovf});
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_cmp_reset();
    great = 1'b1;
    issue(4'd11);
    checks++;
    if (strb !== 10'd0) begin errors++; $display("FAIL cmp_strb got=%b exp=0", strb); end
    tick();
    great = 1'b0;
    checks++;
    if ({flag, instr_ready} !== 2'b11) begin errors++; $display("FAIL cmp_flag got=%b exp=11", {flag, instr_ready}); end
    pointerA = 5'd2;
    pointerB = 5'd0;
    issue(4'd4);
    checks++;
    if (pushB !== 1'b1) begin errors++; $display("FAIL movb2_step1 got=%b exp=1", pushB); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (popA !== 1'b0) begin errors++; $display("FAIL reset_mask_popa got=%b exp=0", popA); end
    tick();
    checks++;
    if ({flag, instr_ready, popA} !== 3'b000) begin
      errors++; $display("FAIL reset_abort got=%b exp=000", {flag, instr_ready, popA});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({instr_ready, popA} !== 2'b10) begin errors++; $display("FAIL post_reset got=%b exp=10", {instr_ready, popA}); end
    tick();
    checks++;
    if (popA !== 1'b0) begin errors++; $display("FAIL post_reset_popa got=%b exp=0", popA); end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_movb();
    test_overflow();
    test_underflow();
    test_alu();
    test_single_ops();
    test_movb_abort();
    test_cmp_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
